// File: rtl/stream_chk_pkg.sv
// Shared types and helpers for the stream tolerance checker.
package stream_chk_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDonePass,
      StDoneFail
   } chk_state_e;

   // Widest lane mask the popcount helper accepts; narrower masks are zero-extended.
   localparam int unsigned MaxLanes = 64;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Width of a lane index; a single-lane checker still gets a 1-bit field.
   function automatic int unsigned lane_idx_w(input int unsigned lanes);
      return (lanes > 1) ? clog2(lanes) : 1;
   endfunction

   function automatic int unsigned popcount(input logic [MaxLanes-1:0] v);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < int'(MaxLanes); i++) begin
         if (v[i]) begin
            cnt = cnt + 1;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/tol_lane_cmp.sv
// Single-lane signed compare with a symmetric inclusive tolerance window.
module tol_lane_cmp #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned TOL    = 3
) (
   input  logic [DATA_W-1:0] dut_i,
   input  logic [DATA_W-1:0] gold_i,
   output logic              err_o
);

   localparam logic signed [DATA_W+1:0] TolPos = (DATA_W+2)'(TOL);
   localparam logic signed [DATA_W+1:0] TolNeg = -TolPos;

   logic signed [DATA_W+1:0] dut_ext;
   logic signed [DATA_W+1:0] gold_ext;
   logic signed [DATA_W+1:0] diff;

   // Widen before subtracting so extreme values never wrap into a false match.
   always_comb begin
      dut_ext  = {{2{dut_i[DATA_W-1]}}, dut_i};
      gold_ext = {{2{gold_i[DATA_W-1]}}, gold_i};
      diff     = dut_ext - gold_ext;
      err_o    = (diff > TolPos) || (diff < TolNeg);
   end

endmodule

// File: rtl/stream_tol_checker.sv
// Streaming BIST checker: compares DUT beats against a synchronous golden ROM with
// a per-lane tolerance, counts lane errors, captures the first failure and reports.
module stream_tol_checker
   import stream_chk_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned LANES      = 16,
   parameter int unsigned TOL        = 3,
   parameter int unsigned FAIL_LIMIT = 48,
   parameter int unsigned NUM_BEATS  = 64,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          start_i,
   input  logic                          dut_valid_i,
   input  logic [LANES*DATA_W-1:0]       dut_data_i,
   output logic [ADDR_W-1:0]             gold_addr_o,
   input  logic [LANES*DATA_W-1:0]       gold_data_i,
   output logic                          cmp_valid_o,
   output logic [LANES-1:0]              lane_err_o,
   output logic [CNT_W-1:0]              err_cnt_o,
   output logic [ADDR_W-1:0]             first_err_idx_o,
   output logic [lane_idx_w(LANES)-1:0]  first_err_lane_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          pass_o
);

   localparam int unsigned     LaneW    = lane_idx_w(LANES);
   localparam logic [ADDR_W:0] NumBeats = (ADDR_W+1)'(NUM_BEATS);
   localparam logic [ADDR_W:0] LastIdx  = (ADDR_W+1)'(NUM_BEATS - 1);
   localparam logic [CNT_W:0]  FailLim  = (CNT_W+1)'(FAIL_LIMIT);

   chk_state_e              state_q, state_d;
   // One bit wider than the ROM address so a full 2^ADDR_W run cannot wrap.
   logic [ADDR_W:0]         idx_q, idx_d;
   logic                    s1_vld_q, s1_vld_d;
   logic [LANES*DATA_W-1:0] s1_data_q;
   logic [ADDR_W:0]         s1_idx_q;
   logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
   logic                    first_seen_q, first_seen_d;
   logic [ADDR_W-1:0]       first_idx_q, first_idx_d;
   logic [LaneW-1:0]        first_lane_q, first_lane_d;

   logic [LANES-1:0]        lane_err_raw;
   logic [LANES-1:0]        lane_err;
   logic [CNT_W:0]          cnt_sum;
   logic [CNT_W-1:0]        cnt_upd;
   logic [LaneW-1:0]        low_lane;
   logic                    accept;
   logic                    abort;
   logic                    last_cmp;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      tol_lane_cmp #(
         .DATA_W (DATA_W),
         .TOL    (TOL)
      ) u_cmp (
         .dut_i  (s1_data_q[l*DATA_W +: DATA_W]),
         .gold_i (gold_data_i[l*DATA_W +: DATA_W]),
         .err_o  (lane_err_raw[l])
      );
   end

   // Qualified error mask, saturated running count and lowest failing lane of this beat.
   always_comb begin
      lane_err = s1_vld_q ? lane_err_raw : '0;
      cnt_sum  = {1'b0, err_cnt_q} + (CNT_W+1)'(popcount(MaxLanes'(lane_err)));
      cnt_upd  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      low_lane = '0;
      for (int i = int'(LANES) - 1; i >= 0; i--) begin
         if (lane_err[i]) begin
            low_lane = LaneW'(i);
         end
      end
   end

   // Next-state logic: run control, beat acceptance, statistics and first-error capture.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      s1_vld_d     = 1'b0;
      err_cnt_d    = err_cnt_q;
      first_seen_d = first_seen_q;
      first_idx_d  = first_idx_q;
      first_lane_d = first_lane_q;
      accept       = 1'b0;
      abort        = 1'b0;
      last_cmp     = 1'b0;

      if (start_i) begin
         // Restart from any state; a beat presented alongside start is discarded.
         state_d      = StRun;
         idx_d        = '0;
         err_cnt_d    = '0;
         first_seen_d = 1'b0;
         first_idx_d  = '0;
         first_lane_d = '0;
      end else if (state_q == StRun) begin
         if (s1_vld_q) begin
            err_cnt_d = cnt_upd;
            if (!first_seen_q && (lane_err != '0)) begin
               first_seen_d = 1'b1;
               first_idx_d  = s1_idx_q[ADDR_W-1:0];
               first_lane_d = low_lane;
            end
            abort    = ({1'b0, cnt_upd} >= FailLim);
            last_cmp = (s1_idx_q == LastIdx);
         end

         // An abort drops whatever beat would enter stage 1 this cycle.
         accept = dut_valid_i && (idx_q < NumBeats) && !abort;
         if (accept) begin
            idx_d    = idx_q + (ADDR_W+1)'(1);
            s1_vld_d = 1'b1;
         end

         if (abort) begin
            state_d = StDoneFail;
         end else if (last_cmp) begin
            state_d = (cnt_upd == '0) ? StDonePass : StDoneFail;
         end
      end
   end

   // State, pipeline and statistics registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         s1_vld_q     <= 1'b0;
         s1_data_q    <= '0;
         s1_idx_q     <= '0;
         err_cnt_q    <= '0;
         first_seen_q <= 1'b0;
         first_idx_q  <= '0;
         first_lane_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         s1_vld_q     <= s1_vld_d;
         err_cnt_q    <= err_cnt_d;
         first_seen_q <= first_seen_d;
         first_idx_q  <= first_idx_d;
         first_lane_q <= first_lane_d;
         if (accept) begin
            s1_data_q <= dut_data_i;
            s1_idx_q  <= idx_q;
         end
      end
   end

   // The ROM samples the index of the beat being accepted on the same edge.
   assign gold_addr_o      = idx_q[ADDR_W-1:0];
   assign cmp_valid_o      = s1_vld_q;
   assign lane_err_o       = lane_err;
   assign err_cnt_o        = err_cnt_q;
   assign first_err_idx_o  = first_idx_q;
   assign first_err_lane_o = first_lane_q;
   assign busy_o           = (state_q == StRun);
   assign done_o           = (state_q == StDonePass) || (state_q == StDoneFail);
   assign pass_o           = (state_q == StDonePass);

endmodule

// File: tb/tb_stream_tol_checker.sv
// Directed bench: a 1-lane and a 16-lane checker, each fed by a modelled sync ROM.
module tb_stream_tol_checker;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // 1-lane instance, 8 beats per run
   logic        start1, valid1;
   logic [15:0] data1, gold1;
   logic [9:0]  ga1, fei1;
   logic        cv1, busy1, done1, pass1;
   logic [0:0]  le1, fel1;
   logic [15:0] ec1;

   // 16-lane instance, 8 beats per run, abort at 48 lane errors
   logic         start16, valid16;
   logic [255:0] data16, gold16;
   logic [9:0]   ga16, fei16;
   logic         cv16, busy16, done16, pass16;
   logic [15:0]  le16, ec16;
   logic [3:0]   fel16;

   logic [15:0]  rom1 [8];
   logic [255:0] rom16 [8];

   int n_chk;
   int n_bad;

   stream_tol_checker #(
      .DATA_W(16), .LANES(1), .TOL(3), .FAIL_LIMIT(48), .NUM_BEATS(8), .ADDR_W(10), .CNT_W(16)
   ) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .dut_valid_i(valid1), .dut_data_i(data1),
      .gold_addr_o(ga1), .gold_data_i(gold1), .cmp_valid_o(cv1), .lane_err_o(le1),
      .err_cnt_o(ec1), .first_err_idx_o(fei1), .first_err_lane_o(fel1), .busy_o(busy1),
      .done_o(done1), .pass_o(pass1)
   );

   stream_tol_checker #(
      .DATA_W(16), .LANES(16), .TOL(3), .FAIL_LIMIT(48), .NUM_BEATS(8), .ADDR_W(10), .CNT_W(16)
   ) u_dut16 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .dut_valid_i(valid16), .dut_data_i(data16),
      .gold_addr_o(ga16), .gold_data_i(gold16), .cmp_valid_o(cv16), .lane_err_o(le16),
      .err_cnt_o(ec16), .first_err_idx_o(fei16), .first_err_lane_o(fel16), .busy_o(busy16),
      .done_o(done16), .pass_o(pass16)
   );

   // Golden ROMs with one cycle of read latency
   always @(posedge clk) begin
      gold1  <= rom1[ga1[2:0]];
      gold16 <= rom16[ga16[2:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] beat16(input int b);
      logic [255:0] v;
      for (int l = 0; l < 16; l++) v[l*16 +: 16] = 16'(b * 256 + l * 16);
      return v;
   endfunction

   // Tolerance table for the 1-lane run: golden, DUT, expected lane_err, err_cnt seen
   logic [15:0] gtab [8] = '{16'h0100, 16'h0100, 16'h0100, 16'h7FFF,
                             16'h8000, 16'hFFFE, 16'hFFFE, 16'h1234};
   logic [15:0] dtab [8] = '{16'h0103, 16'h00FD, 16'h0104, 16'h8000,
                             16'h8003, 16'h0001, 16'h0002, 16'h1234};
   logic        etab [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   int          ctab [8] = '{0, 0, 0, 1, 2, 2, 2, 3};

   initial begin
      int           ncmp;
      logic [255:0] v;
      logic [15:0]  exp_le;

      n_chk = 0; n_bad = 0;
      rst_n = 1'b0;
      start1 = 1'b0; valid1 = 1'b0; data1 = '0;
      start16 = 1'b0; valid16 = 1'b0; data16 = '0;
      for (int i = 0; i < 8; i++) begin
         rom1[i]  = 16'h1000 + 16'(i);
         rom16[i] = beat16(i);
      end
      repeat (3) tick();

      // Reset state
      check_eq("rst_gold_addr", {ga1, ga16}, 0);
      check_eq("rst_err_cnt", {ec1, ec16}, 0);
      check_eq("rst_flags", {busy1, done1, pass1, cv1, busy16, done16, pass16, cv16}, 0);
      check_eq("rst_first", {fei1, fel1, fei16, fel16}, 0);
      rst_n = 1'b1;
      tick();

      // 1-lane back-to-back clean run
      start1 = 1'b1; tick(); start1 = 1'b0;
      check_eq("t1_busy", busy1, 1);
      ncmp = 0;
      for (int i = 0; i < 8; i++) begin
         valid1 = 1'b1; data1 = rom1[i]; tick();
         if (cv1) ncmp++;
         check_eq($sformatf("t1_lane_err[%0d]", i), le1, 0);
      end
      valid1 = 1'b0; tick();
      check_eq("t1_cmp_count", ncmp, 8);
      check_eq("t1_err_cnt", ec1, 0);
      check_eq("t1_done_pass_busy_cv", {done1, pass1, busy1, cv1}, 4'b1100);
      check_eq("t1_gold_addr", ga1, 8);

      // Tolerance edges, including the 0x7FFF / 0x8000 non-wrap case
      for (int i = 0; i < 8; i++) rom1[i] = gtab[i];
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         valid1 = 1'b1; data1 = dtab[i]; tick();
         check_eq($sformatf("t2_lane_err[%0d]", i), le1, etab[i]);
         check_eq($sformatf("t2_err_cnt[%0d]", i), ec1, ctab[i]);
      end
      valid1 = 1'b0; tick();
      check_eq("t2_err_cnt_end", ec1, 3);
      check_eq("t2_done_pass", {done1, pass1}, 2'b10);
      check_eq("t2_first_idx", fei1, 2);
      check_eq("t2_first_lane", fel1, 0);

      // Gapped valid, then start mid-run with a coincident valid
      for (int i = 0; i < 8; i++) rom1[i] = 16'h2000 + 16'(i);
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int b = 0; b < 3; b++) begin
         valid1 = 1'b1;
         data1  = (b == 1) ? rom1[b] + 16'd10 : rom1[b];
         tick();
         check_eq($sformatf("t3_cv_on[%0d]", b), cv1, 1);
         valid1 = 1'b0; tick();
         check_eq($sformatf("t3_cv_off_a[%0d]", b), cv1, 0);
         tick();
         check_eq($sformatf("t3_cv_off_b[%0d]", b), cv1, 0);
      end
      check_eq("t3_gold_addr_mid", ga1, 3);
      check_eq("t3_err_cnt_mid", ec1, 1);
      check_eq("t3_first_idx_mid", fei1, 1);
      start1 = 1'b1; valid1 = 1'b1; data1 = 16'hDEAD; tick();
      start1 = 1'b0; valid1 = 1'b0;
      check_eq("t3_restart_cv", cv1, 0);
      check_eq("t3_restart_err_cnt", ec1, 0);
      check_eq("t3_restart_gold_addr", ga1, 0);
      check_eq("t3_restart_first_idx", fei1, 0);
      check_eq("t3_restart_busy", busy1, 1);
      ncmp = 0;
      for (int i = 0; i < 8; i++) begin
         valid1 = 1'b1; data1 = rom1[i]; tick();
         if (cv1) ncmp++;
      end
      valid1 = 1'b0; tick();
      check_eq("t3_rerun_cmp_count", ncmp, 8);
      check_eq("t3_rerun_done_pass", {done1, pass1, ec1}, {2'b11, 16'd0});

      // 16 lanes: first error in beat 5 (lanes 2, 9), later error in beat 7
      start16 = 1'b1; tick(); start16 = 1'b0;
      for (int b = 0; b < 8; b++) begin
         v = beat16(b);
         exp_le = '0;
         if (b == 5) begin
            v[2*16 +: 16] = v[2*16 +: 16] + 16'd4;
            v[9*16 +: 16] = v[9*16 +: 16] - 16'd4;
            v[3*16 +: 16] = v[3*16 +: 16] + 16'd3;
            exp_le = 16'h0204;
         end
         if (b == 7) begin
            v[0 +: 16] = v[0 +: 16] + 16'd5;
            exp_le = 16'h0001;
         end
         valid16 = 1'b1; data16 = v; tick();
         check_eq($sformatf("t4_lane_err[%0d]", b), le16, exp_le);
         if (b == 6) check_eq("t4_err_cnt_after_b5", ec16, 2);
      end
      valid16 = 1'b0; tick();
      check_eq("t4_err_cnt_end", ec16, 3);
      check_eq("t4_first_idx", fei16, 5);
      check_eq("t4_first_lane", fel16, 2);
      check_eq("t4_done_pass", {done16, pass16}, 2'b10);

      // Every lane wrong: abort once the count reaches 48
      start16 = 1'b1; tick(); start16 = 1'b0;
      ncmp = 0;
      for (int b = 0; b < 8; b++) begin
         v = beat16(b);
         for (int l = 0; l < 16; l++) v[l*16 +: 16] = v[l*16 +: 16] + 16'd100;
         valid16 = 1'b1; data16 = v; tick();
         if (cv16) ncmp++;
      end
      valid16 = 1'b0; tick();
      check_eq("t5_cmp_count", ncmp, 3);
      check_eq("t5_err_cnt", ec16, 48);
      check_eq("t5_done_pass_busy", {done16, pass16, busy16}, 3'b100);
      check_eq("t5_gold_addr", ga16, 3);
      check_eq("t5_first", {fei16, fel16}, 0);

      // Reset mid-run with a beat in the compare stage, then valid while idle
      start16 = 1'b1; tick(); start16 = 1'b0;
      v = beat16(0);
      v[0 +: 16] = v[0 +: 16] + 16'd50;
      valid16 = 1'b1; data16 = v; tick();
      check_eq("t6_pre_rst_cmp", {cv16, le16}, {1'b1, 16'h0001});
      rst_n = 1'b0; data16 = beat16(1); tick();
      check_eq("t6_rst_cmp", {cv16, le16}, 0);
      check_eq("t6_rst_err_cnt", ec16, 0);
      check_eq("t6_rst_gold_addr", ga16, 0);
      check_eq("t6_rst_flags", {busy16, done16, pass16}, 0);
      check_eq("t6_rst_first", {fei16, fel16}, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq($sformatf("t6_idle[%0d]", k), {cv16, busy16, ga16, ec16}, 0);
      end
      valid16 = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
